// File: rtl/mul_booth32_pkg.sv
// ---------------------------------------------------------------------------
// mul_defs -- shared definitions for the radix-2 Booth multiplier slice.
//
// Purpose : holds the controller state encoding and the step-count constant
//           so the top level and anything that inspects it agree on them.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package mul_defs;

  // Controller states: waiting, stepping through Booth iterations, holding
  // a finished product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // One Booth step per multiplier bit.
  localparam int         STEPS     = 32;
  localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);

endpackage

// File: rtl/mul_booth32_addsub33.sv
// ---------------------------------------------------------------------------
// addsub33 -- 33-bit adder/subtractor built from 4-bit carry-lookahead groups.
//
// Purpose : s = a + b when sub=0, s = a + ~b + 1 when sub=1 (modulo 2^33).
// Ports   : a[32:0]  first operand
//           b[32:0]  second operand
//           sub      1 = subtract b, 0 = add b
//           s[32:0]  result
// ---------------------------------------------------------------------------
module addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] s
);

  logic [32:0] bEff;
  logic [8:0]  groupCarry;

  // Subtraction is two's-complement addition: invert b and feed the
  // carry-in of the lowest group with a one.
  assign bEff          = b ^ {33{sub}};
  assign groupCarry[0] = sub;

  // Eight 4-bit lookahead groups cover bits 31:0; each group resolves its
  // internal carries in parallel and hands its carry-out to the next group.
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : gCla
      logic [3:0] grpGen;
      logic [3:0] grpProp;
      logic [3:0] carry;
      logic       cin;

      assign cin     = groupCarry[g];
      assign grpGen  = a[4*g +: 4] & bEff[4*g +: 4];
      assign grpProp = a[4*g +: 4] ^ bEff[4*g +: 4];

      assign carry[0] = cin;
      assign carry[1] = grpGen[0] | (grpProp[0] & cin);
      assign carry[2] = grpGen[1] | (grpProp[1] & grpGen[0])
                      | (grpProp[1] & grpProp[0] & cin);
      assign carry[3] = grpGen[2] | (grpProp[2] & grpGen[1])
                      | (grpProp[2] & grpProp[1] & grpGen[0])
                      | (grpProp[2] & grpProp[1] & grpProp[0] & cin);
      assign groupCarry[g+1] = grpGen[3] | (grpProp[3] & grpGen[2])
                             | (grpProp[3] & grpProp[2] & grpGen[1])
                             | (grpProp[3] & grpProp[2] & grpProp[1] & grpGen[0])
                             | (&grpProp & cin);

      assign s[4*g +: 4] = grpProp ^ carry;
    end
  endgenerate

  // Bit 32 is the sign-extension bit; its carry-out is never needed.
  assign s[32] = a[32] ^ bEff[32] ^ groupCarry[8];

endmodule

// File: rtl/mul_booth32.sv
// ---------------------------------------------------------------------------
// mul_booth32 -- sequential radix-2 Booth multiplier, 32x32 -> 64 signed.
//
// Purpose : multiplies two signed 32-bit operands one Booth step per clock.
//           A start in IDLE or DONE latches the operands; the product is
//           valid while op_done is high and is held until cleared/restarted.
// Ports   : clk           rising-edge clock
//           reset_n       asynchronous active-low reset
//           op_start      begin a multiply (ignored while busy)
//           op_clear      synchronous abort/clear, wins over op_start
//           multiplicand  signed operand M
//           multiplier    signed operand Q
//           op_busy       high while stepping
//           op_done       high while the product is valid
//           result        {U, L} accumulator, the product when op_done=1
// Config  : define MUL_EARLY_TERM_EN to finish as soon as the remaining
//           multiplier bits can only produce shifts.
// ---------------------------------------------------------------------------
module mul_booth32
  import mul_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_start,
  input  logic        op_clear,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        op_busy,
  output logic        op_done,
  output logic [63:0] result
);

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] upper_q, upper_d;
  logic [31:0] lower_q, lower_d;
  logic        q1_q, q1_d;
  logic [4:0]  count_q, count_d;

  logic [32:0] addA, addB, sum33;
  logic        addSub;
  logic [31:0] shiftUpper, shiftLower;
  logic [31:0] stepUpper, stepLower;
  logic        earlyTerm, finishStep;

  // Booth recoding of {L[0], q_1}: 01 adds M, 10 subtracts M, otherwise the
  // adder just passes U through. Both operands are sign-extended to 33 bits
  // so that subtracting the most negative M cannot overflow.
  always_comb begin
    addA   = {upper_q[31], upper_q};
    addB   = 33'd0;
    addSub = 1'b0;
    case ({lower_q[0], q1_q})
      2'b01: addB = {mcand_q[31], mcand_q};
      2'b10: begin
        addB   = {mcand_q[31], mcand_q};
        addSub = 1'b1;
      end
      default: ;
    endcase
  end

  addsub33 uAddSub (
    .a   (addA),
    .b   (addB),
    .sub (addSub),
    .s   (sum33)
  );

  // Arithmetic right shift of {sum33, L, q_1}; the shifted-out L[0] becomes
  // the new q_1 and sum33[32] is the replicated sign.
  assign shiftUpper = sum33[32:1];
  assign shiftLower = {sum33[0], lower_q[31:1]};

`ifdef MUL_EARLY_TERM_EN
  logic [4:0]         remaining;
  logic [31:0]        pendMask;
  logic signed [63:0] flushed;

  // After this step, the low 'remaining' bits of L are still-unprocessed
  // multiplier bits and L[0] of this step becomes q_1. If they are all equal,
  // every later step recodes to "no add", so the rest collapses into one
  // arithmetic shift by 'remaining'.
  always_comb begin
    remaining = LAST_STEP - count_q;
    pendMask  = (32'd1 << remaining) - 32'd1;
    if (lower_q[0]) begin
      earlyTerm = ((shiftLower & pendMask) == pendMask);
    end else begin
      earlyTerm = ((shiftLower & pendMask) == 32'd0);
    end
    flushed   = $signed({shiftUpper, shiftLower}) >>> remaining;
    stepUpper = earlyTerm ? flushed[63:32] : shiftUpper;
    stepLower = earlyTerm ? flushed[31:0]  : shiftLower;
  end
`else
  assign earlyTerm = 1'b0;
  assign stepUpper = shiftUpper;
  assign stepLower = shiftLower;
`endif

  assign finishStep = (count_q == LAST_STEP) || earlyTerm;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear dominates, and a start is only honoured when
  // not already stepping.
  always_comb begin
    state_d = state_q;
    if (op_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (op_start)   state_d = EXEC;
        EXEC:       if (finishStep) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    op_busy = (state_q == EXEC);
    op_done = (state_q == DONE);
  end

  assign result = {upper_q, lower_q};

  // Datapath next values: clear zeroes the accumulator, a start loads the
  // operands, and each EXEC cycle performs one Booth step.
  always_comb begin
    mcand_d = mcand_q;
    upper_d = upper_q;
    lower_d = lower_q;
    q1_d    = q1_q;
    count_d = count_q;
    if (op_clear) begin
      upper_d = 32'd0;
      lower_d = 32'd0;
      q1_d    = 1'b0;
      count_d = 5'd0;
    end else if (state_q == EXEC) begin
      upper_d = stepUpper;
      lower_d = stepLower;
      q1_d    = lower_q[0];
      count_d = count_q + 5'd1;
    end else if (op_start) begin
      mcand_d = multiplicand;
      upper_d = 32'd0;
      lower_d = multiplier;
      q1_d    = 1'b0;
      count_d = 5'd0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q <= 32'd0;
      upper_q <= 32'd0;
      lower_q <= 32'd0;
      q1_q    <= 1'b0;
      count_q <= 5'd0;
    end else begin
      mcand_q <= mcand_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
      q1_q    <= q1_d;
      count_q <= count_d;
    end
  end

endmodule
